// File: rtl/vlog_pkg.sv
// vlog_pkg: shared types and constants for the FP16 natural-log unit.
//   fp16_t          raw IEEE half-precision bit pattern
//   FP16_* consts   special encodings emitted by the special-case override
//   LN2_Q16         ln(2) in Q0.16
//   special_e       operand class resolved in S1, applied in S3
//   s1_t            S1 -> S2 pipeline register contents
//   lut_base()      ln(1 + i/16) in Q0.16 for i = 0..16 (segment knots)
package vlog_pkg;
   typedef logic [15:0] fp16_t;

   localparam fp16_t       FP16_PINF = 16'h7C00;
   localparam fp16_t       FP16_NINF = 16'hFC00;
   localparam fp16_t       FP16_QNAN = 16'h7E00;
   localparam fp16_t       FP16_ZERO = 16'h0000;
   localparam logic [15:0] LN2_Q16   = 16'hB172;
   localparam int          STAGES    = 3;

   typedef enum logic [1:0] {SP_NONE, SP_NINF, SP_QNAN, SP_PINF} special_e;

   typedef struct packed {
      special_e   sp;
      logic [5:0] k;    // unbiased exponent, two's complement
      logic [3:0] idx;  // segment index, mantissa[9:6]
      logic [5:0] f;    // position inside segment, mantissa[5:0]
   } s1_t;

   // Knot i is round(ln(1 + i/16) * 2^16); knot 16 equals LN2_Q16 so the
   // last segment lands exactly on ln(2). Segment slope = knot[i+1] - knot[i].
   function automatic logic [15:0] lut_base(input logic [4:0] i);
      case (i)
         5'd0:    return 16'd0;
         5'd1:    return 16'd3973;
         5'd2:    return 16'd7719;
         5'd3:    return 16'd11262;
         5'd4:    return 16'd14624;
         5'd5:    return 16'd17821;
         5'd6:    return 16'd20870;
         5'd7:    return 16'd23783;
         5'd8:    return 16'd26573;
         5'd9:    return 16'd29248;
         5'd10:   return 16'd31818;
         5'd11:   return 16'd34292;
         5'd12:   return 16'd36675;
         5'd13:   return 16'd38975;
         5'd14:   return 16'd41196;
         5'd15:   return 16'd43345;
         default: return LN2_Q16;
      endcase
   endfunction
endpackage

// File: rtl/vlog_if.sv
// vlog_if: valid/ready stream bundle around the log unit.
//   operand/valid_in/ready_in    upstream side (FP16 x)
//   result/valid_out/ready_out   downstream side (FP16 ln(x))
//   slave  : the vlog unit
//   master : whoever drives operands and consumes results
interface vlog_if;
   import vlog_pkg::*;

   fp16_t operand;
   logic  valid_in;
   logic  ready_in;
   fp16_t result;
   logic  valid_out;
   logic  ready_out;

   modport slave  (input  operand, valid_in, ready_out,
                   output ready_in, result, valid_out);
   modport master (output operand, valid_in, ready_out,
                   input  ready_in, result, valid_out);
endinterface

// File: rtl/vlog_norm.sv
// vlog_norm: combinational signed Q5.16 -> FP16 conversion.
//   i_sum  signed 22-bit fixed-point log value (16 fraction bits)
//   o_res  FP16 encoding, round-to-nearest-even; zero maps to +0
module vlog_norm
   import vlog_pkg::*;
(
   input  logic signed [21:0] i_sum,
   output fp16_t              o_res
);
   logic        w_neg;
   logic [21:0] w_mag;
   logic [4:0]  w_msb;
   logic        w_lead;
   logic [20:0] w_n;
   logic        w_rnd;
   logic [10:0] w_mant_r;
   logic [4:0]  w_exp;

   always_comb begin
      w_neg = i_sum[21];
      w_mag = w_neg ? 22'(-i_sum) : 22'(i_sum);

      // highest set bit wins
      w_msb = '0;
      for (int i = 0; i < 22; i++)
         if (w_mag[i]) w_msb = 5'(i);

      // left-justify so the hidden 1 sits at w_lead; w_lead is 0 only for zero
      {w_lead, w_n} = w_mag << (5'd21 - w_msb);

      // guard = w_n[10], sticky = w_n[9:0], lsb = w_n[11]
      w_rnd    = w_n[10] & ((|w_n[9:0]) | w_n[11]);
      w_mant_r = {1'b0, w_n[20:11]} + 11'(w_rnd);

      // bias 15, binary point at bit 16; mantissa carry bumps the exponent
      w_exp = w_msb - 5'd1 + 5'(w_mant_r[10]);
      o_res = w_lead ? {w_neg, w_exp, w_mant_r[9:0]} : FP16_ZERO;
   end
endmodule

// File: rtl/vlog.sv
// vlog: 3-stage FP16 natural-log unit behind a valid/ready handshake.
//   CLK   rising-edge clock
//   RST   asynchronous active-high reset
//   bus   vlog_if.slave: operand/valid_in/ready_in in, result/valid_out/ready_out out
// S1 unpacks and classifies, S2 forms k*ln2 + piecewise-linear ln(1.m),
// S3 converts to FP16 and applies special-case overrides. A single advance
// signal stalls every stage together.
module vlog
   import vlog_pkg::*;
(
   input  logic CLK,
   input  logic RST,
   vlog_if.slave bus
);
   logic [STAGES-1:0] r_vld_pipe;
   s1_t               r_s1;
   special_e          r_sp2;
   logic signed [21:0] r_sum;
   fp16_t             r_res;

   logic              w_adv;
   s1_t               w_s1;
   logic [15:0]       w_base;
   logic [15:0]       w_slope;
   logic [21:0]       w_prod;
   logic [15:0]       w_lnm;
   logic signed [21:0] w_k_ext;
   logic signed [21:0] w_kln2;
   logic signed [21:0] w_sum;
   fp16_t             w_norm;
   fp16_t             w_res;

   // the output register is the only place backpressure can originate
   assign w_adv         = !r_vld_pipe[STAGES-1] | bus.ready_out;
   assign bus.ready_in  = w_adv;
   assign bus.valid_out = r_vld_pipe[STAGES-1];
   assign bus.result    = r_res;

   // S1: unpack and classify
   always_comb begin
      w_s1     = '0;
      w_s1.k   = 6'({1'b0, bus.operand[14:10]}) - 6'd15;
      w_s1.idx = bus.operand[9:6];
      w_s1.f   = bus.operand[5:0];
      w_s1.sp  = SP_NONE;
      if (bus.operand[14:10] == 5'd0)
         w_s1.sp = SP_NINF;                  // zeros and flushed subnormals
      else if (bus.operand[14:10] == 5'h1F)
         w_s1.sp = (bus.operand[9:0] != '0 || bus.operand[15]) ? SP_QNAN : SP_PINF;
      else if (bus.operand[15])
         w_s1.sp = SP_QNAN;
   end

   // S2: ln(x) = k*ln2 + ln(1.m); |sum| < 2^20 so 22 bits never overflow
   always_comb begin
      w_base  = lut_base({1'b0, r_s1.idx});
      w_slope = lut_base({1'b0, r_s1.idx} + 5'd1) - w_base;
      w_prod  = 22'(w_slope) * 22'(r_s1.f);
      w_lnm   = w_base + 16'(w_prod >> 6);
      w_k_ext = 22'($signed(r_s1.k));
      w_kln2  = w_k_ext * $signed({6'd0, LN2_Q16});
      w_sum   = w_kln2 + $signed({6'd0, w_lnm});
   end

   // S3: pack and override
   vlog_norm u_norm (.i_sum(r_sum), .o_res(w_norm));

   always_comb begin
      case (r_sp2)
         SP_NINF: w_res = FP16_NINF;
         SP_QNAN: w_res = FP16_QNAN;
         SP_PINF: w_res = FP16_PINF;
         default: w_res = w_norm;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_vld_pipe <= '0;
         r_s1       <= '0;
         r_sp2      <= SP_NONE;
         r_sum      <= '0;
         r_res      <= FP16_ZERO;
      end else if (w_adv) begin
         r_vld_pipe <= {r_vld_pipe[STAGES-2:0], bus.valid_in};
         r_s1       <= w_s1;
         r_sp2      <= r_s1.sp;
         r_sum      <= w_sum;
         // bubbles leave the last delivered result on the bus
         if (r_vld_pipe[STAGES-2]) r_res <= w_res;
      end
   end
endmodule

// File: tb/tb_vlog.sv
module tb_vlog;
   import vlog_pkg::*;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   vlog_if bus ();
   vlog dut (.CLK(CLK), .RST(RST), .bus(bus));

   always #5 CLK = ~CLK;

   // ---------------- reference model ----------------
   function automatic int knot_q16(input int i);
      return $rtoi($ln(1.0 + real'(i) / 16.0) * 65536.0 + 0.5);
   endfunction

   // exact real-valued conversion of a Q16 integer to FP16 with RNE
   function automatic logic [15:0] to_fp16(input longint s);
      logic sg;
      real  v, sc, fr;
      int   e, q;
      if (s == 0) return 16'h0000;
      sg = (s < 0);
      v  = real'(sg ? -s : s) / 65536.0;
      e  = 0;
      while (v >= 2.0) begin v = v / 2.0; e++; end
      while (v < 1.0)  begin v = v * 2.0; e--; end
      sc = (v - 1.0) * 1024.0;
      q  = $rtoi(sc);
      fr = sc - real'(q);
      if (fr > 0.5 || (fr == 0.5 && q[0])) q++;
      if (q == 1024) begin q = 0; e++; end
      return {sg, 5'(e + 15), 10'(q)};
   endfunction

   function automatic logic [15:0] ref_vlog(input logic [15:0] x);
      int     k, idx, f, b0, b1, lnm;
      longint sum;
      if (x[14:10] == 5'd0)  return 16'hFC00;
      if (x[14:10] == 5'h1F) return (x[9:0] != 0 || x[15]) ? 16'h7E00 : 16'h7C00;
      if (x[15])             return 16'h7E00;
      k   = int'(x[14:10]) - 15;
      idx = int'(x[9:6]);
      f   = int'(x[5:0]);
      b0  = knot_q16(idx);
      b1  = knot_q16(idx + 1);
      lnm = b0 + ((b1 - b0) * f) / 64;
      sum = longint'(k) * 32'hB172 + longint'(lnm);
      return to_fp16(sum);
   endfunction

   function automatic logic [15:0] rand_op(input int mode, input int n);
      logic [15:0] x;
      if (mode == 2) return 16'h0400 + 16'(n);
      x = 16'($urandom);
      if (mode == 1 || $urandom_range(0, 3) != 0)
         x = {1'b0, 5'($urandom_range(1, 30)), 10'($urandom)};
      return x;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      bit seen;
      bus.valid_in = 1'b0; bus.ready_out = 1'b1; bus.operand = '0;
      #1 RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      n_checks++; if (bus.valid_out !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid_out); end
      n_checks++; if (bus.result !== 16'h0000) begin n_errors++; $display("FAIL reset_result: got %h expected 0000", bus.result); end
      @(negedge CLK) RST = 1'b0;
      #1;
      n_checks++; if (bus.ready_in !== 1'b1) begin n_errors++; $display("FAIL reset_ready_in: got %b expected 1", bus.ready_in); end
      // fill the pipe, then reset while valid_out is high and valid_in still asserted
      @(negedge CLK); bus.valid_in = 1'b1; bus.operand = 16'h4000;
      repeat (3) @(posedge CLK);
      #2;
      n_checks++; if (bus.valid_out !== 1'b1) begin n_errors++; $display("FAIL reset_prefill: got %b expected 1", bus.valid_out); end
      RST = 1'b1;
      #1;
      n_checks++; if (bus.valid_out !== 1'b0) begin n_errors++; $display("FAIL reset_async_valid: got %b expected 0", bus.valid_out); end
      n_checks++; if (bus.result !== 16'h0000) begin n_errors++; $display("FAIL reset_async_result: got %h expected 0000", bus.result); end
      @(negedge CLK); bus.valid_in = 1'b0; RST = 1'b0;
      seen = 1'b0;
      repeat (6) begin @(negedge CLK); if (bus.valid_out) seen = 1'b1; end
      n_checks++; if (seen) begin n_errors++; $display("FAIL reset_no_output: got output expected none"); end
   endtask

   task automatic test_directed();
      logic [15:0] ops [12] = '{16'h3C00, 16'h0000, 16'h8000, 16'h0001, 16'hBC00, 16'h7E00,
                                16'h7C00, 16'hFC00, 16'h4000, 16'h3800, 16'h4170, 16'h7BFF};
      logic [15:0] exps[12] = '{16'h0000, 16'hFC00, 16'hFC00, 16'hFC00, 16'h7E00, 16'h7E00,
                                16'h7C00, 16'h7E00, 16'h398C, 16'hB98C, 16'h3C00, 16'h498B};
      int lat;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK); bus.ready_out = 1'b1; bus.valid_in = 1'b1; bus.operand = ops[i];
         lat = 0;
         do begin
            @(posedge CLK); lat++;
            @(negedge CLK); bus.valid_in = 1'b0;
         end while (!bus.valid_out && lat < 10);
         n_checks++; if (lat != 3) begin n_errors++; $display("FAIL latency_%h: got %0d expected 3", ops[i], lat); end
         n_checks++; if (bus.result !== exps[i]) begin n_errors++; $display("FAIL value_%h: got %h expected %h", ops[i], bus.result, exps[i]); end
      end
   endtask

   // mode 0: random traffic/backpressure, 1: ready_out toggling, 2: full positive-normal sweep
   task automatic test_stream(input int mode, input int n);
      logic [15:0] exp_q[$];
      logic [15:0] held_val, e;
      int sent, got, cyc;
      bit held;
      sent = 0; got = 0; cyc = 0; held = 1'b0; held_val = '0;
      @(negedge CLK);
      while (got < n && cyc < 40 * n + 100) begin
         if (held) begin
            n_checks++;
            if (bus.result !== held_val) begin n_errors++; $display("FAIL stall_stable_m%0d: got %h expected %h", mode, bus.result, held_val); end
         end
         case (mode)
            0:       bus.ready_out = ($urandom_range(0, 3) != 0);
            1:       bus.ready_out = (cyc[0] == 1'b0);
            default: bus.ready_out = 1'b1;
         endcase
         if (sent < n) begin
            bus.valid_in = (mode == 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.operand  = rand_op(mode, sent);
         end else
            bus.valid_in = 1'b0;
         #1;
         if (bus.valid_out && bus.ready_out) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++; $display("FAIL stream_m%0d_extra: got %h expected no output", mode, bus.result);
            end else begin
               e = exp_q.pop_front();
               if (bus.result !== e) begin n_errors++; $display("FAIL stream_m%0d_#%0d: got %h expected %h", mode, got, bus.result, e); end
            end
            got++;
         end
         if (bus.valid_in && bus.ready_in) begin
            exp_q.push_back(ref_vlog(bus.operand));
            sent++;
         end
         held     = bus.valid_out && !bus.ready_out;
         held_val = bus.result;
         cyc++;
         @(negedge CLK);
      end
      bus.valid_in = 1'b0; bus.ready_out = 1'b1;
      n_checks++; if (got != n) begin n_errors++; $display("FAIL stream_m%0d_count: got %0d expected %0d", mode, got, n); end
   endtask

   task automatic test_full_stall();
      logic [15:0] exp_q[$];
      int acc;
      acc = 0;
      @(negedge CLK); bus.ready_out = 1'b0;
      repeat (6) begin
         bus.valid_in = 1'b1; bus.operand = rand_op(1, 0);
         #1;
         if (bus.ready_in) begin exp_q.push_back(ref_vlog(bus.operand)); acc++; end
         @(negedge CLK);
      end
      n_checks++; if (acc != 3) begin n_errors++; $display("FAIL stall_accepts: got %0d expected 3", acc); end
      n_checks++; if (bus.ready_in !== 1'b0) begin n_errors++; $display("FAIL stall_ready_in: got %b expected 0", bus.ready_in); end
      bus.valid_in = 1'b0; bus.ready_out = 1'b1;
      for (int j = 0; j < 3; j++) begin
         #1;
         n_checks++;
         if (bus.valid_out !== 1'b1 || j >= exp_q.size() || bus.result !== exp_q[j]) begin
            n_errors++; $display("FAIL stall_drain_%0d: got v=%b r=%h expected v=1 r=%h", j, bus.valid_out, bus.result, (j < exp_q.size()) ? exp_q[j] : 16'h0);
         end
         @(negedge CLK);
      end
      n_checks++; if (bus.valid_out !== 1'b0) begin n_errors++; $display("FAIL stall_drained: got %b expected 0", bus.valid_out); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stream(1, 8);
      test_full_stall();
      test_stream(0, 400);
      test_stream(2, 30720);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
